// File: rtl/mem_stage_ctrl.sv
// Y86-64 memory-stage controller: serialises 64-bit loads/stores onto a byte-wide
// data memory, little-endian, and reports completion status.
module mem_stage_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  input  logic        instr_valid,
  input  logic        imem_error,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic [1:0]  stat,
  output logic        dmem_error
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 64;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 3;
  // Highest base address whose eight bytes still fit below 64 KiB.
  localparam logic [DW-1:0] ADDR_LAST = 64'd65528;
  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_drain, w_drain_nxt;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_data;
  logic [1:0]       r_stat;
  logic             r_derr;
  logic             r_re_d;
  logic [DW-BW-1:0] r_rbuf;

  logic             w_is_wr, w_is_rd, w_suppress, w_oob, w_derr, w_go_wr, w_go_rd;
  logic [DW-1:0]    w_req_addr, w_req_data;
  logic [1:0]       w_stat;
  logic [AW-1:0]    w_base, w_addr_nxt;
  logic [DW-1:0]    w_data;
  logic [BW-1:0]    w_wdata_nxt;
  logic             w_we_nxt, w_re_nxt, w_done_nxt, w_busy_nxt;
  logic [1:0]       w_stat_fin;
  logic             w_derr_fin;

  // Request decode straight from the inputs, used in the accepting cycle.
  always_comb begin
    w_is_wr    = 1'b0;
    w_is_rd    = 1'b0;
    w_req_addr = valE;
    w_req_data = valA;
    case (icode)
      4'h4, 4'hA: w_is_wr = 1'b1;
      4'h8: begin
        w_is_wr    = 1'b1;
        w_req_data = valP;
      end
      4'h5: w_is_rd = 1'b1;
      4'h9, 4'hB: begin
        w_is_rd    = 1'b1;
        w_req_addr = valA;
      end
      default: ;
    endcase
    w_suppress = imem_error | ~instr_valid | (icode == 4'h0);
    w_oob      = w_req_addr > ADDR_LAST;
    w_derr     = (w_is_wr | w_is_rd) & ~w_suppress & w_oob;
    w_go_wr    = w_is_wr & ~w_suppress & ~w_oob;
    w_go_rd    = w_is_rd & ~w_suppress & ~w_oob;
    if (imem_error)          w_stat = STAT_ADR;
    else if (!instr_valid)   w_stat = STAT_INS;
    else if (icode == 4'h0)  w_stat = STAT_HLT;
    else if (w_derr)         w_stat = STAT_ADR;
    else                     w_stat = STAT_AOK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // Reads need one extra READ cycle (drain) for the last byte to return.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_drain_nxt = r_drain;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cnt_nxt   = '0;
          w_drain_nxt = 1'b0;
          if (w_go_wr)      w_state_nxt = S_WRITE;
          else if (w_go_rd) w_state_nxt = S_READ;
          else              w_state_nxt = S_DONE;
        end
      end
      S_WRITE: begin
        if (r_cnt == CW'(7)) w_state_nxt = S_DONE;
        else                 w_cnt_nxt   = r_cnt + CW'(1);
      end
      S_READ: begin
        if (r_drain)              w_state_nxt = S_DONE;
        else if (r_cnt == CW'(7)) w_drain_nxt = 1'b1;
        else                      w_cnt_nxt   = r_cnt + CW'(1);
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    w_base      = (r_state == S_IDLE) ? w_req_addr[AW-1:0] : r_addr;
    w_data      = (r_state == S_IDLE) ? w_req_data : r_data;
    w_stat_fin  = (r_state == S_IDLE) ? w_stat : r_stat;
    w_derr_fin  = (r_state == S_IDLE) ? w_derr : r_derr;
    w_we_nxt    = (w_state_nxt == S_WRITE);
    w_re_nxt    = (w_state_nxt == S_READ) && !w_drain_nxt;
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_addr_nxt  = (w_we_nxt || w_re_nxt) ? (w_base + AW'(w_cnt_nxt)) : '0;
    w_wdata_nxt = w_we_nxt ? w_data[{w_cnt_nxt, 3'b000} +: BW] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_data <= '0;
      r_stat <= STAT_AOK;
      r_derr <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_addr <= w_req_addr[AW-1:0];
      r_data <= w_req_data;
      r_stat <= w_stat;
      r_derr <= w_derr;
    end
  end

  // Read bytes shift in from the top; the eighth byte goes straight into valM.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      valM       <= '0;
      stat       <= STAT_AOK;
      dmem_error <= 1'b0;
      r_re_d     <= 1'b0;
      r_rbuf     <= '0;
    end else begin
      mem_we    <= w_we_nxt;
      mem_re    <= w_re_nxt;
      mem_addr  <= w_addr_nxt;
      mem_wdata <= w_wdata_nxt;
      busy      <= w_busy_nxt;
      done      <= w_done_nxt;
      r_re_d    <= mem_re;
      if (r_re_d) r_rbuf <= {mem_rdata, r_rbuf[DW-BW-1:BW]};
      if (w_done_nxt) begin
        stat       <= w_stat_fin;
        dmem_error <= w_derr_fin;
        if (r_state == S_READ) valM <= {mem_rdata, r_rbuf};
      end
    end
  end

endmodule
